// File: rtl/fifo_queue_pkg.sv
// Shared defaults for fifo_queue: data width, depth and the occupancy-counter width.
package fifo_queue_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_DEPTH + 1);

  // Occupancy counter must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_queue_mem.sv
// Queue storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the controller masks stale data.
module fifo_queue_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_dat_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
  end

  assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_queue.sv
// Show-ahead FIFO: q shows the head with zero latency; push is refused when full unless a pop frees a slot
// the same cycle. Defining FIFO_QUEUE_ERR_EN adds sticky overflow/underflow flags cleared only by RST.
module fifo_queue
  import fifo_queue_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW   = cnt_width(DEPTH),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] d,
  input  logic             pop,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
`ifdef FIFO_QUEUE_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_acc, pop_acc;
  logic [WIDTH-1:0] rd_dat;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // A pop frees the slot the simultaneous push lands in, so full does not block it.
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_acc)  head_d = head_q + PW'(1);
    if (push_acc) tail_d = tail_q + PW'(1);
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fifo_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk_i     (CLK),
    .wr_en_i   (push_acc & ~RST),
    .wr_addr_i (tail_q),
    .wr_dat_i  (d),
    .rd_addr_i (head_q),
    .rd_dat_o  (rd_dat)
  );

  assign q = empty ? '0 : rd_dat;

`ifdef FIFO_QUEUE_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (push & ~push_acc);
    underflow_d = underflow_q | (pop & empty);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_queue.sv
// Directed-vector bench for fifo_queue (default 32x16), plus hand sequences for full/wrap/reset corners.
module tb_fifo_queue;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [31:0] d = '0;
  logic [31:0] q;
  logic        empty;
  logic        full;
  logic [4:0]  count;
`ifdef FIFO_QUEUE_ERR_EN
  logic        overflow;
  logic        underflow;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  fifo_queue dut (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .d     (d),
    .pop   (pop),
    .q     (q),
    .empty (empty),
    .full  (full),
    .count (count)
`ifdef FIFO_QUEUE_ERR_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  typedef struct {
    logic        push;
    logic        pop;
    logic [31:0] d;
    logic [31:0] cnt;
    logic        emp;
    logic        ful;
    logic [31:0] q;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic o, input logic [31:0] dv);
    push = p;
    pop  = o;
    d    = dv;
    @(posedge CLK);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    logic [31:0] sb[$];
    logic [31:0] exp_head;
    logic        p, o, pa, oa;
    int          pushed, ncyc;

    tv[0] = '{1'b1, 1'b0, 32'd3, 32'd1, 1'b0, 1'b0, 32'd3};
    tv[1] = '{1'b1, 1'b0, 32'd4, 32'd2, 1'b0, 1'b0, 32'd3};
    tv[2] = '{1'b1, 1'b0, 32'd7, 32'd3, 1'b0, 1'b0, 32'd3};
    tv[3] = '{1'b0, 1'b1, 32'd0, 32'd2, 1'b0, 1'b0, 32'd4};
    tv[4] = '{1'b0, 1'b1, 32'd0, 32'd1, 1'b0, 1'b0, 32'd7};
    tv[5] = '{1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0};
    tv[6] = '{1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0};
    tv[7] = '{1'b1, 1'b1, 32'd5, 32'd1, 1'b0, 1'b0, 32'd5};
    tv[8] = '{1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0};

    #2;
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_q", q, 32'd0);
`ifdef FIFO_QUEUE_ERR_EN
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
`endif

    // Basic order, pop on empty, and pop-on-empty with simultaneous push.
    for (int i = 0; i < 9; i++) begin
      cyc(tv[i].push, tv[i].pop, tv[i].d);
      chk($sformatf("tv%0d_count", i), 32'(count), tv[i].cnt);
      chk($sformatf("tv%0d_empty", i), 32'(empty), 32'(tv[i].emp));
      chk($sformatf("tv%0d_full", i), 32'(full), 32'(tv[i].ful));
      chk($sformatf("tv%0d_q", i), q, tv[i].q);
    end
`ifdef FIFO_QUEUE_ERR_EN
    chk("underflow_sticky", 32'(underflow), 32'd1);
    chk("overflow_clear", 32'(overflow), 32'd0);
`endif

    // Fill to full, refused 17th push, drain in order.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 32'(i));
      chk("fill_count", 32'(count), 32'(i));
    end
    chk("fill_full", 32'(full), 32'd1);
    cyc(1'b1, 1'b0, 32'd99);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_q", q, 32'd1);
`ifdef FIFO_QUEUE_ERR_EN
    chk("overflow_set", 32'(overflow), 32'd1);
`endif
    for (int i = 1; i <= 16; i++) begin
      chk("drain_q", q, 32'(i));
      cyc(1'b0, 1'b1, 32'd0);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_q0", q, 32'd0);

    // Full queue, push and pop together.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 32'(i));
    cyc(1'b1, 1'b1, 32'd42);
    chk("pp_count", 32'(count), 32'd16);
    chk("pp_full", 32'(full), 32'd1);
    for (int i = 2; i <= 16; i++) begin
      chk("pp_q", q, 32'(i));
      cyc(1'b0, 1'b1, 32'd0);
    end
    chk("pp_42", q, 32'd42);
    chk("pp_count1", 32'(count), 32'd1);
    cyc(1'b0, 1'b1, 32'd0);
    chk("pp_empty", 32'(empty), 32'd1);

    // Random push/pop mix against a scoreboard.
    pushed = 0;
    ncyc   = 0;
    while ((pushed < 40 || sb.size() > 0) && ncyc < 2000) begin
      p  = (pushed < 40) && ($urandom_range(0, 2) != 0);
      o  = ($urandom_range(0, 1) == 1);
      exp_head = (sb.size() > 0) ? sb[0] : 32'd0;
      chk("rnd_q", q, exp_head);
      oa = o && (sb.size() > 0);
      pa = p && ((sb.size() < 16) || oa);
      cyc(p, o, 32'(1000 + pushed));
      if (oa) void'(sb.pop_front());
      if (pa) begin
        sb.push_back(32'(1000 + pushed));
        pushed++;
      end
      chk("rnd_count", 32'(count), 32'(sb.size()));
      ncyc++;
    end
    if (ncyc >= 2000) begin
      nvec++;
      nerr++;
      $display("FAIL rnd_timeout: got %0d cycles, expected < 2000", ncyc);
    end

    // Reset with entries present and a push pending.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'(10 + i));
    chk("pre_rst_count", 32'(count), 32'd5);
    push = 1'b1;
    d    = 32'd77;
    RST  = 1'b1;
    @(posedge CLK);
    #1;
    RST  = 1'b0;
    push = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_q", q, 32'd0);
`ifdef FIFO_QUEUE_ERR_EN
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_underflow", 32'(underflow), 32'd0);
`endif
    cyc(1'b1, 1'b0, 32'd88);
    chk("post_rst_q", q, 32'd88);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
